tt_um_johnson: RTL and testbench
================================

TT_UM_JOHNSON -- requirements
Module: tt_um_johnson

Interface
REQ-001 Parameter WIDTH, default 8: Johnson register width; legal range 2..8; the cycle length is 2*WIDTH states.
REQ-002 Parameter DIV, default 1: prescaler ratio; the counter advances once every DIV clocks; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-high; the name is retained for harness compatibility, and asserted means rst_n=1.
REQ-005 uo_out  output  8  Johnson register state; bits at index WIDTH and above are driven 0.
REQ-006 Reset is synchronous and active-high on one clock, clk, with no other clock or asynchronous input.

Function
REQ-007 Johnson state q[WIDTH-1:0] SHALL shift left on each step: q_next = {q[WIDTH-2:0], ~q[WIDTH-1]}.
REQ-008 Sequence for WIDTH=8 SHALL be 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80, then wrap to 00 (period 16 steps).
REQ-009 A step SHALL occur on a clock edge where the prescaler tick is 1.
REQ-010 Prescaler: a 16-bit down-counter reloads to DIV-1 and asserts tick when at 0; for DIV=1, tick is constantly 1.
REQ-011 uo_out SHALL be registered, equal to q, with zero combinational path from inputs.
REQ-012 Latency: with DIV=1, the first clock edge with rst_n=0 after reset SHALL produce uo_out=01.
REQ-013 Exactly one bit SHALL change per step; uo_out[0] SHALL be high for WIDTH steps, then low for WIDTH steps.
REQ-014 Illegal states are any q not of the form 0^a1^b or 1^a0^b, i.e. more than one 0/1 boundary in the linear word.
REQ-015 Self-correction: on a step, an illegal q SHALL load 0 instead of the shift result, so recovery completes within one step.
REQ-016 Between ticks (DIV>1), q SHALL hold its value.

Reset
REQ-017 While rst_n=1 at a clock edge, q SHALL load 0, uo_out SHALL be 00, and the prescaler SHALL load DIV-1.
REQ-018 Reset SHALL take priority over step and correction in the same cycle.
REQ-019 Reset asserted mid-sequence SHALL return uo_out to 00 on that edge, with no residual state.
REQ-020 Reset SHALL NOT be required for the prescaler value before the first reset; post-power-up X is permitted until the first reset.

Structure
REQ-021 A shared package johnson_pkg SHALL hold the WIDTH/DIV defaults, the prescaler width constant (16), and the legality-check function.
REQ-022 One sub-module, johnson_prescaler, SHALL implement the tick generator; the Johnson register and correction logic reside in tt_um_johnson.

Verification
REQ-023 Scenario: hold rst_n=1 for 3 clocks, then release -> uo_out=00 during reset, then 01,03,07 on the next three edges.
REQ-024 Scenario: run 32 clocks after reset (DIV=1) -> exact REQ-008 sequence twice, wrapping 80->00, and uo_out[0] 8-high/8-low.
REQ-025 Scenario: assert rst_n=1 when uo_out=F0 -> uo_out=00 on the same edge, then the sequence restarts at 01.
REQ-026 Scenario: DIV=4 -> uo_out changes only every 4th clock (00,00,00,00,01,...), with period 64 clocks.
REQ-027 Scenario: force q=0x55 for one cycle, then release -> next step yields 00, then 01,03 as normal.
REQ-028 Scenario: WIDTH=4 -> sequence 0,1,3,7,F,E,C,8,0 with uo_out[7:4]=0 throughout.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared constants and the Johnson-word legality check used by the
// tt_um_johnson counter and its prescaler.
package johnson_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned DIV_DEFAULT   = 1;
    localparam int unsigned PRESCALE_W    = 16;

    // A legal Johnson word has at most one 0/1 boundary across its low 'width' bits.
    function automatic logic is_legal(input logic [7:0] q, input int unsigned width);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 0; i + 1 < width; i++) begin
            if (q[i] != q[i+1]) edges++;
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/johnson_prescaler.sv
// Tick generator: a down-counter reloading to DIV-1, ticking when it reaches 0.
module johnson_prescaler
    import johnson_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] RELOAD = PRESCALE_W'(DIV - 1);
    localparam logic [PRESCALE_W-1:0] ONE    = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - ONE;
        end
    end

    // DIV=1 ticks every clock, independent of any pre-reset counter value.
    assign tick = (DIV == 1) ? 1'b1 : (cnt == '0);

endmodule

// File: rtl/tt_um_johnson.sv
// Self-correcting Johnson counter with a prescaled step rate; rst_n is
// active-high despite its name.
module tt_um_johnson
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DIV   = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] uo_out
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_shift;
    logic [7:0]       q_ext;
    logic             tick;

    johnson_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst_n),
        .tick (tick)
    );

    assign q_shift = {q[WIDTH-2:0], ~q[WIDTH-1]};

    always_comb begin
        q_ext            = '0;
        q_ext[WIDTH-1:0] = q;
    end

    // An illegal word is flushed to 0 on the step rather than shifted.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            q <= '0;
        end else if (tick) begin
            if (!is_legal(q_ext, WIDTH)) begin
                q <= '0;
            end else begin
                q <= q_shift;
            end
        end
    end

    assign uo_out = q_ext;

endmodule

// File: tb/tb_tt_um_johnson.sv
// Self-checking bench for tt_um_johnson across three configurations.
module tb_tt_um_johnson;

    logic       clk;
    logic       rst_n;
    logic [7:0] uo_a;
    logic [7:0] uo_b;
    logic [7:0] uo_c;

    int cmp_count;
    int err_count;
    int n;

    tt_um_johnson #(.WIDTH(8), .DIV(1)) dut_a (.clk(clk), .rst_n(rst_n), .uo_out(uo_a));
    tt_um_johnson #(.WIDTH(8), .DIV(4)) dut_b (.clk(clk), .rst_n(rst_n), .uo_out(uo_b));
    tt_um_johnson #(.WIDTH(4), .DIV(1)) dut_c (.clk(clk), .rst_n(rst_n), .uo_out(uo_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: after n non-reset edges there have been n/d steps; the
    // Johnson word after k steps is k ones (k<=w) or ones with k-w low zeros.
    function automatic logic [7:0] model(input int steps_edges, input int w, input int d);
        int k;
        int v;
        k = (steps_edges / d) % (2 * w);
        if (k <= w) v = (1 << k) - 1;
        else        v = ((1 << w) - 1) & ~((1 << (k - w)) - 1);
        return 8'(v);
    endfunction

    task automatic cycle(input logic r);
        rst_n = r;
        @(posedge clk);
        #1;
        if (r) n = 0;
        else   n++;
    endtask

    task automatic test_reset();
        logic [7:0] want [3];
        want[0] = 8'h01; want[1] = 8'h03; want[2] = 8'h07;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            cmp_count++;
            if (uo_a !== 8'h00 || uo_b !== 8'h00 || uo_c !== 8'h00) begin
                err_count++;
                $display("FAIL reset_hold[%0d]: got a=%h b=%h c=%h want 00", i, uo_a, uo_b, uo_c);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            cmp_count++;
            if (uo_a !== want[i]) begin
                err_count++;
                $display("FAIL reset_release[%0d]: got %h want %h", i, uo_a, want[i]);
            end
        end
    endtask

    task automatic test_sequence();
        logic [7:0] seq [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        logic [7:0] prev;
        int         ones;
        cycle(1'b1);
        prev = uo_a;
        ones = 0;
        for (int i = 1; i <= 32; i++) begin
            cycle(1'b0);
            cmp_count++;
            if (uo_a !== seq[i % 16]) begin
                err_count++;
                $display("FAIL seq[%0d]: got %h want %h", i, uo_a, seq[i % 16]);
            end
            cmp_count++;
            if ($countones(uo_a ^ prev) != 1) begin
                err_count++;
                $display("FAIL one_bit_change[%0d]: got %h->%h want single-bit change", i, prev, uo_a);
            end
            if (uo_a[0]) ones++;
            prev = uo_a;
        end
        cmp_count++;
        if (ones != 16) begin
            err_count++;
            $display("FAIL bit0_duty: got %0d high edges want 16", ones);
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        cycle(1'b1);
        guard = 0;
        while (uo_a !== 8'hF0 && guard < 40) begin
            cycle(1'b0);
            guard++;
        end
        cmp_count++;
        if (uo_a !== 8'hF0) begin
            err_count++;
            $display("FAIL reach_F0: got %h want f0 within 40 clocks", uo_a);
        end
        cycle(1'b1);
        cmp_count++;
        if (uo_a !== 8'h00) begin
            err_count++;
            $display("FAIL mid_reset: got %h want 00", uo_a);
        end
        cycle(1'b0);
        cmp_count++;
        if (uo_a !== 8'h01) begin
            err_count++;
            $display("FAIL mid_reset_restart: got %h want 01", uo_a);
        end
    endtask

    task automatic test_prescaler();
        logic [7:0] prev;
        logic [7:0] exp_v;
        cycle(1'b1);
        prev = uo_b;
        for (int i = 0; i < 70; i++) begin
            cycle(1'b0);
            exp_v = model(n, 8, 4);
            cmp_count++;
            if (uo_b !== exp_v) begin
                err_count++;
                $display("FAIL div4[%0d]: got %h want %h", n, uo_b, exp_v);
            end
            if (n % 4 != 0) begin
                cmp_count++;
                if (uo_b !== prev) begin
                    err_count++;
                    $display("FAIL div4_hold[%0d]: got %h want %h", n, uo_b, prev);
                end
            end
            prev = uo_b;
        end
    endtask

    task automatic test_width4();
        logic [7:0] seq [8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E, 8'h0C, 8'h08};
        cycle(1'b1);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0);
            cmp_count++;
            if (uo_c !== seq[i % 8]) begin
                err_count++;
                $display("FAIL width4[%0d]: got %h want %h", i, uo_c, seq[i % 8]);
            end
        end
    endtask

    task automatic test_correction();
        logic [7:0] want [3];
        want[0] = 8'h00; want[1] = 8'h01; want[2] = 8'h03;
        cycle(1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0);
        force dut_a.q = 8'h55;
        #1;
        release dut_a.q;
        cmp_count++;
        if (uo_a !== 8'h55) begin
            err_count++;
            $display("FAIL force_visible: got %h want 55", uo_a);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            cmp_count++;
            if (uo_a !== want[i]) begin
                err_count++;
                $display("FAIL correction[%0d]: got %h want %h", i, uo_a, want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] ec;
        cycle(1'b1);
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 23) == 0);
            ea = model(n, 8, 1);
            eb = model(n, 8, 4);
            ec = model(n, 4, 1);
            cmp_count++;
            if (uo_a !== ea || uo_b !== eb || uo_c !== ec) begin
                err_count++;
                $display("FAIL random[%0d]: got a=%h b=%h c=%h want a=%h b=%h c=%h",
                         i, uo_a, uo_b, uo_c, ea, eb, ec);
            end
        end
    endtask

    initial begin
        cmp_count = 0;
        err_count = 0;
        n         = 0;
        rst_n     = 1'b1;
        test_reset();
        test_sequence();
        test_mid_reset();
        test_prescaler();
        test_width4();
        test_correction();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
